// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data memory with one-entry store buffer, load forwarding and alignment/range checks
module data_mem_ctrl #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  st_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_err
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic          buf_v;
  logic [AW-1:0] buf_idx;
  logic [3:0]    buf_be;
  logic [31:0]   buf_d;
  logic [AW-1:0] idx;
  logic          st, oor, st_bad, ld_bad, st_ok, hit;
  logic [3:0]    be;
  logic [31:0]   wd, merged;
  assign idx    = addr[AW+1:2];
  assign st     = |st_op;
  assign oor    = addr >= 32'(4 * DEPTH);
  assign st_bad = oor | (st_op == 2'b01 ? |addr[1:0] : st_op == 2'b10 && addr[0]);
  assign ld_bad = oor | (ld_size == 2'b10 ? 1'b0 : ld_size == 2'b01 ? addr[0] : |addr[1:0]);
  assign st_ok  = st & ~st_bad;
  assign be     = st_op == 2'b01 ? 4'hf : st_op == 2'b10 ? (addr[1] ? 4'hc : 4'h3) : 4'b1 << addr[1:0];
  assign wd     = st_op == 2'b01 ? wdata : st_op == 2'b10 ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  assign hit    = buf_v && buf_idx == idx;
  always_comb begin
    merged = mem[idx];
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = hit && buf_be[b] ? buf_d[8*b +: 8] : mem[idx][8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      buf_v       <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      // the buffered entry always retires on the edge after capture, so a new store can take its place
      if (buf_v)
        for (int b = 0; b < 4; b++)
          if (buf_be[b]) mem[buf_idx][8*b +: 8] <= buf_d[8*b +: 8];
      buf_v <= st_ok;
      if (st_ok) begin
        buf_idx <= idx;
        buf_be  <= be;
        buf_d   <= wd;
      end
      rdata_valid <= ld & ~st;
      addr_err    <= st ? (ld | st_bad) : ld & ld_bad;
      if (ld & ~st) rdata <= ld_bad ? '0 : merged;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: table-driven and randomised checks of data_mem_ctrl against a flat byte-lane memory model
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld = 1'b0;
  logic [1:0]  ld_size = 2'b00;
  logic [1:0]  st_op = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid, addr_err;

  data_mem_ctrl #(.DEPTH(4096)) dut (
    .clk(clk), .reset_n(reset_n), .ld(ld), .ld_size(ld_size), .st_op(st_op),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] wd;
    logic        v;
    logic        e;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic        v;
    logic        e;
    logic [31:0] r;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  logic [31:0] mm [4096];
  logic [31:0] last = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, act, req);
    end
  endtask

  task automatic check();
    exp_t x;
    if (sb.size() == 0) return;
    x = sb.pop_front();
    cmp("rdata_valid", 32'(rdata_valid), 32'(x.v));
    cmp("addr_err", 32'(addr_err), 32'(x.e));
    cmp("rdata", rdata, x.r);
  endtask

  task automatic model(input logic l, input logic [1:0] sz, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t x);
    logic oor, bad;
    int   w;
    oor = a >= 32'h4000;
    w   = int'(a[13:2]);
    x.r = last;
    if (s != 2'b00) begin
      bad = oor || (s == 2'b01 && a[1:0] != 2'b00) || (s == 2'b10 && a[0]);
      x.v = 1'b0;
      x.e = l || bad;
      if (!bad) begin
        if (s == 2'b01) mm[w] = wd;
        else if (s == 2'b10) begin
          if (a[1]) mm[w][31:16] = wd[15:0];
          else      mm[w][15:0]  = wd[15:0];
        end else mm[w][8*a[1:0] +: 8] = wd[7:0];
      end
    end else if (l) begin
      bad = oor || (sz == 2'b01 ? a[0] : sz == 2'b10 ? 1'b0 : a[1:0] != 2'b00);
      x.v = 1'b1;
      x.e = bad;
      x.r = bad ? 32'h0 : mm[w];
      last = x.r;
    end else begin
      x.v = 1'b0;
      x.e = 1'b0;
    end
  endtask

  task automatic cyc(input logic l, input logic [1:0] sz, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] wd,
                     input bit use_t, input exp_t tx);
    exp_t x;
    @(posedge clk);
    #1;
    check();
    ld = l; ld_size = sz; st_op = s; addr = a; wdata = wd;
    model(l, sz, s, a, wd, x);
    sb.push_back(use_t ? tx : x);
  endtask

  task automatic idle();
    exp_t d;
    d = '{1'b0, 1'b0, 32'h0};
    cyc(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    check();
    reset_n = 1'b0;
    ld = 1'b1; st_op = 2'b01; addr = 32'h60; wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_rdata", rdata, 32'h0);
    cmp("rst_valid", 32'(rdata_valid), 32'h0);
    cmp("rst_err", 32'(addr_err), 32'h0);
    reset_n = 1'b1;
    ld = 1'b0; st_op = 2'b00;
    sb.delete();
    for (int i = 0; i < 4096; i++) mm[i] = '0;
    last = '0;
  endtask

  initial begin
    exp_t tx, d;
    d = '{1'b0, 1'b0, 32'h0};
    //             ld   sz     st     addr        wdata         v     e     rdata
    tbl.push_back('{1'b0, 2'b00, 2'b01, 32'h10,   32'h11223344, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h10,   32'h0,        1'b1, 1'b0, 32'h11223344});
    tbl.push_back('{1'b0, 2'b00, 2'b01, 32'h20,   32'hAABBCCDD, 1'b0, 1'b0, 32'h11223344});
    tbl.push_back('{1'b0, 2'b00, 2'b11, 32'h21,   32'h55,       1'b0, 1'b0, 32'h11223344});
    tbl.push_back('{1'b0, 2'b00, 2'b10, 32'h22,   32'h1234,     1'b0, 1'b0, 32'h11223344});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h20,   32'h0,        1'b1, 1'b0, 32'h123455DD});
    tbl.push_back('{1'b0, 2'b00, 2'b10, 32'h31,   32'hABCD,     1'b0, 1'b1, 32'h123455DD});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h30,   32'h0,        1'b1, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h4000, 32'h0,        1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h10,   32'h0,        1'b1, 1'b0, 32'h11223344});
    tbl.push_back('{1'b1, 2'b01, 2'b00, 32'h13,   32'h0,        1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b10, 2'b00, 32'h13,   32'h0,        1'b1, 1'b0, 32'h11223344});
    tbl.push_back('{1'b1, 2'b00, 2'b01, 32'h50,   32'h0000CAFE, 1'b0, 1'b1, 32'h11223344});
    tbl.push_back('{1'b0, 2'b00, 2'b00, 32'h0,    32'h0,        1'b0, 1'b0, 32'h11223344});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h50,   32'h0,        1'b1, 1'b0, 32'h0000CAFE});
    tbl.push_back('{1'b0, 2'b00, 2'b01, 32'h3FFC, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0000CAFE});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h3FFC, 32'h0,        1'b1, 1'b0, 32'hCAFEBABE});
    tbl.push_back('{1'b0, 2'b00, 2'b11, 32'h4001, 32'h77,       1'b0, 1'b1, 32'hCAFEBABE});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h2,    32'h0,        1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h60,   32'h0,        1'b1, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b00, 2'b01, 32'h70,   32'h01020304, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b00, 2'b10, 32'h70,   32'hBEEF,     1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 2'b00, 2'b00, 32'h70,   32'h0,        1'b1, 1'b0, 32'h0102BEEF});
    tbl.push_back('{1'b1, 2'b11, 2'b00, 32'h72,   32'h0,        1'b1, 1'b1, 32'h0});

    do_reset();
    foreach (tbl[i]) begin
      tx = '{tbl[i].v, tbl[i].e, tbl[i].r};
      cyc(tbl[i].ld, tbl[i].sz, tbl[i].st, tbl[i].a, tbl[i].wd, 1'b1, tx);
    end
    idle();

    // store left in the buffer when reset hits must vanish
    cyc(1'b0, 2'b00, 2'b01, 32'h40, 32'hDEADBEEF, 1'b0, d);
    do_reset();
    tx = '{1'b1, 1'b0, 32'h0};
    cyc(1'b1, 2'b00, 2'b00, 32'h40, 32'h0, 1'b1, tx);
    idle();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom % 8 == 0) ? 32'h3FF8 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 63));
      cyc(1'($urandom % 2), 2'($urandom % 4), ($urandom % 2 == 0) ? 2'b00 : 2'($urandom % 4),
          a, $urandom, 1'b0, d);
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
